sfi_guard: RTL

- Registered, parametrised software-fault-isolation guard for a stream of DATA_W-bit words.
- The effective address sits in the top ADDR_W bits of each word.
- Each word is checked against NUM_REGIONS programmable base/mask windows. Passing words go through unchanged; violating words are zeroed and flagged.
- Sits between the instruction/address producer and the memory-issue stage. Adds valid/ready flow control, runtime region configuration, violation counting and a sticky fault.

---
 rtl/sfi_guard_if.sv | 25 ++
 rtl/sfi_guard.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sfi_guard_if.sv
// Stream interface for the SFI guard: input word handshake on one side,
// checked output word plus violation flag on the other.
// The guard connects through the slave modport; the producer/consumer
// environment connects through the master modport.
interface sfi_guard_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_viol;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_viol
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_viol
    );
endinterface

// File: rtl/sfi_guard.sv
// Software-fault-isolation guard. Each accepted word's effective address
// (top ADDR_W bits) is matched against NUM_REGIONS base/mask windows.
// Passing words are forwarded unchanged; violating words are zeroed,
// flagged, counted (saturating) and set a sticky fault.
// Optional macro SFI_TRAP_EN: once a violation is accepted the input is
// stalled until fault_clr is pulsed.
module sfi_guard #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 32,
    parameter int                NUM_REGIONS = 4,
    parameter int                CNT_W       = 16,
    parameter logic [ADDR_W-1:0] RST_BASE0   = 32'hA2190000,
    parameter logic [ADDR_W-1:0] RST_MASK0   = 32'hFFFF0000,
    localparam int               IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    sfi_guard_if.slave        bus,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic              cfg_en,
    input  logic              fault_clr,
    output logic              fault,
    output logic [CNT_W-1:0]  viol_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADDR_W-1:0]      baseTable_q [NUM_REGIONS];
    logic [ADDR_W-1:0]      maskTable_q [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] enTable_q;

    logic [ADDR_W-1:0]      wordAddr;
    logic [NUM_REGIONS-1:0] regionHit;
    logic                   wordPass;
    logic                   inReady;
    logic                   acceptWord;
    logic                   cfgIdxOk;

    logic                   outValid_q, outValid_d;
    logic [DATA_W-1:0]      outData_q,  outData_d;
    logic                   outViol_q,  outViol_d;
    logic                   fault_q,    fault_d;
    logic [CNT_W-1:0]       violCnt_q,  violCnt_d;

    assign wordAddr = bus.in_data[DATA_W-1 -: ADDR_W];
    assign cfgIdxOk = ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_REGIONS));

    // Region table: reset restores window 0 only, writes to absent slots are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                baseTable_q[i] <= '0;
                maskTable_q[i] <= '0;
            end
            baseTable_q[0] <= RST_BASE0;
            maskTable_q[0] <= RST_MASK0;
            enTable_q      <= NUM_REGIONS'(1);
        end else if (cfg_we && cfgIdxOk) begin
            baseTable_q[cfg_idx] <= cfg_base;
            maskTable_q[cfg_idx] <= cfg_mask;
            enTable_q[cfg_idx]   <= cfg_en;
        end
    end

    // Window match uses the registered table, so a same-cycle write only affects later words.
    always_comb begin
        regionHit = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            regionHit[i] = enTable_q[i] &&
                           ((wordAddr & maskTable_q[i]) == (baseTable_q[i] & maskTable_q[i]));
        end
    end

    assign wordPass = |regionHit;

`ifdef SFI_TRAP_EN
    assign inReady = (!outValid_q || bus.out_ready) && (!fault_q || fault_clr);
`else
    assign inReady = !outValid_q || bus.out_ready;
`endif

    assign acceptWord = bus.in_valid && inReady;

    // Output register: load on accept, otherwise drop valid once the consumer takes the word.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outViol_d  = outViol_q;
        if (acceptWord) begin
            outValid_d = 1'b1;
            outData_d  = wordPass ? bus.in_data : '0;
            outViol_d  = !wordPass;
        end else if (bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Fault/counter update: a violation accepted alongside fault_clr restarts the count at one.
    always_comb begin
        fault_d   = fault_q;
        violCnt_d = violCnt_q;
        if (fault_clr) begin
            fault_d   = 1'b0;
            violCnt_d = '0;
        end
        if (acceptWord && !wordPass) begin
            fault_d   = 1'b1;
            violCnt_d = (violCnt_d == CNT_MAX) ? violCnt_d : violCnt_d + CNT_W'(1);
        end
    end

    // State registers for the output stage and the violation bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outViol_q  <= 1'b0;
            fault_q    <= 1'b0;
            violCnt_q  <= '0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outViol_q  <= outViol_d;
            fault_q    <= fault_d;
            violCnt_q  <= violCnt_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign bus.out_viol  = outViol_q;
    assign fault         = fault_q;
    assign viol_cnt      = violCnt_q;

endmodule
